// File: rtl/mr_ldst_pipe.sv
// Pipelined load/store unit between EX and WB, mastering a pipelined Wishbone B4 bus.
// Keeps per-request metadata in a small FIFO so responses can be steered back in order.
module mr_ldst_pipe #(
    parameter int XLEN            = 32,
    parameter int REGSEL_BITS     = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int GRAN            = $clog2(XLEN/8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             ex_op_i,
    input  logic [1:0]             ex_size_i,
    input  logic                   ex_signed_i,
    input  logic [XLEN-1:0]        ex_addr_i,
    input  logic [XLEN-1:0]        ex_payload_i,
    input  logic [REGSEL_BITS-1:0] ex_dst_reg_i,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    output logic                   wb_write,
    output logic [XLEN-1:0]        wb_payload_o,
    output logic [REGSEL_BITS-1:0] wb_dst_reg_o,
    output logic                   fault_o,
    output logic [1:0]             fault_code_o,
    output logic [XLEN-1:0]        fault_addr_o,
    output logic [XLEN-GRAN-1:0]   addr_o,
    output logic                   we_o,
    output logic [XLEN/8-1:0]      sel_o,
    output logic [XLEN-1:0]        dat_o,
    output logic                   stb_o,
    output logic                   cyc_o,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   stall_i,
    input  logic [XLEN-1:0]        dat_i
);

    localparam int NB  = XLEN / 8;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;
    localparam int SW  = $clog2(XLEN);
    localparam bit IS32 = (XLEN == 32);

    logic [1:0]             fifo_size [MAX_OUTSTANDING];
    logic                   fifo_sgn  [MAX_OUTSTANDING];
    logic                   fifo_load [MAX_OUTSTANDING];
    logic [REGSEL_BITS-1:0] fifo_dst  [MAX_OUTSTANDING];
    logic [XLEN-1:0]        fifo_addr [MAX_OUTSTANDING];

    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;

    logic is_load, is_store, is_mem, illegal_size, misaligned, issue_op;
    logic err_take, pop, push, accept, ready_base;

    always_comb begin
        is_load      = (ex_op_i == 2'd1);
        is_store     = (ex_op_i == 2'd2);
        is_mem       = is_load | is_store;
        illegal_size = (ex_size_i == 2'd3) && IS32;
        case (ex_size_i)
            2'd1:    misaligned = ex_addr_i[0];
            2'd2:    misaligned = |ex_addr_i[1:0];
            2'd3:    misaligned = |ex_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
        issue_op = is_mem & !illegal_size & !misaligned;
    end

    // An error only matters while something is outstanding; new requests are held off that
    // cycle so the flush cannot swallow them.
    assign err_take   = err_i & cyc_o & (count_reg != '0);
    assign pop        = ack_i & (count_reg != '0) & !err_take;
    assign ready_base = !(stb_o & stall_i) & (count_reg < CW'(MAX_OUTSTANDING))
                        & !fault_o & !err_take;
    assign ex_ready_o = ready_base & (issue_op | ((count_reg == '0) & !stb_o));
    assign accept     = ex_valid_i & ex_ready_o;
    assign push       = accept & issue_op;
    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Byte-lane enables and per-size replication of the store payload.
    logic [NB-1:0]   sel_next;
    logic [XLEN-1:0] dat_next;
    logic [4:0]      lane_lo, lane_hi;
    logic [GRAN-1:0] size_mask;

    assign lane_lo   = 5'(ex_addr_i[GRAN-1:0]);
    assign lane_hi   = lane_lo + (5'd1 << ex_size_i);
    assign size_mask = GRAN'((4'd1 << ex_size_i) - 4'd1);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [GRAN-1:0] ridx;
            assign ridx = GRAN'(gi) & size_mask;
            assign sel_next[gi] = (5'(gi) >= lane_lo) && (5'(gi) < lane_hi);
            assign dat_next[8*gi +: 8] = ex_payload_i[8*ridx +: 8];
        end
    endgenerate

    // Response steering: shift the addressed lane down, then mask and extend by size.
    logic [1:0]      head_size;
    logic [XLEN-1:0] head_addr, shifted, mask, load_val;
    logic [6:0]      sh_bits;
    logic [SW-1:0]   sign_idx;
    logic            sbit;

    always_comb begin
        head_size = fifo_size[rd_ptr_reg];
        head_addr = fifo_addr[rd_ptr_reg];
        shifted   = dat_i >> {head_addr[GRAN-1:0], 3'b000};
        sh_bits   = 7'd8 << head_size;
        mask      = (XLEN'(1) << sh_bits) - XLEN'(1);
        sign_idx  = SW'(sh_bits - 7'd1);
        sbit      = fifo_sgn[rd_ptr_reg] & shifted[sign_idx];
        load_val  = (shifted & mask) | ({XLEN{sbit}} & ~mask);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_size[wr_ptr_reg] <= ex_size_i;
            fifo_sgn[wr_ptr_reg]  <= ex_signed_i;
            fifo_load[wr_ptr_reg] <= is_load;
            fifo_dst[wr_ptr_reg]  <= ex_dst_reg_i;
            fifo_addr[wr_ptr_reg] <= ex_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stb_o      <= 1'b0;
            cyc_o      <= 1'b0;
            wb_write   <= 1'b0;
            fault_o    <= 1'b0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wb_write <= 1'b0;
            fault_o  <= 1'b0;
            if (push) begin
                stb_o  <= 1'b1;
                addr_o <= ex_addr_i[XLEN-1:GRAN];
                we_o   <= is_store;
                sel_o  <= sel_next;
                dat_o  <= dat_next;
            end else if (!(stb_o & stall_i)) begin
                stb_o <= 1'b0;
            end

            if (err_take) begin
                stb_o        <= 1'b0;
                cyc_o        <= 1'b0;
                count_reg    <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                fault_o      <= 1'b1;
                fault_code_o <= 2'd2;
                fault_addr_o <= head_addr;
            end else begin
                cyc_o     <= push | (count_next != '0);
                count_reg <= count_next;
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (fifo_load[rd_ptr_reg]) begin
                        wb_write     <= 1'b1;
                        wb_payload_o <= load_val;
                        wb_dst_reg_o <= fifo_dst[rd_ptr_reg];
                    end
                end
                if (accept && !issue_op) begin
                    if (is_mem) begin
                        fault_o      <= 1'b1;
                        fault_code_o <= illegal_size ? 2'd3 : 2'd1;
                        fault_addr_o <= ex_addr_i;
                    end else begin
                        wb_write     <= 1'b1;
                        wb_payload_o <= ex_addr_i;
                        wb_dst_reg_o <= ex_dst_reg_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mr_ldst_pipe.sv
// Directed bench for mr_ldst_pipe: a 32-bit instance for most scenarios and a 64-bit
// instance for the doubleword/halfword lane checks.
module tb_mr_ldst_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit instance
    logic [1:0]  op = '0, size = '0;
    logic        sgn = 1'b0, valid = 1'b0, ack = 1'b0, err = 1'b0, stall = 1'b0;
    logic [31:0] addr = '0, pay = '0, dat_in = '0;
    logic [4:0]  dst = '0;
    logic        rdy, wbw, flt, we, stb, cyc;
    logic [31:0] wb_pay, f_addr, dat_out;
    logic [4:0]  wb_dst;
    logic [1:0]  f_code;
    logic [29:0] bus_addr;
    logic [3:0]  sel;

    mr_ldst_pipe #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst),
        .ex_op_i(op), .ex_size_i(size), .ex_signed_i(sgn), .ex_addr_i(addr),
        .ex_payload_i(pay), .ex_dst_reg_i(dst), .ex_valid_i(valid), .ex_ready_o(rdy),
        .wb_write(wbw), .wb_payload_o(wb_pay), .wb_dst_reg_o(wb_dst),
        .fault_o(flt), .fault_code_o(f_code), .fault_addr_o(f_addr),
        .addr_o(bus_addr), .we_o(we), .sel_o(sel), .dat_o(dat_out),
        .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err), .stall_i(stall), .dat_i(dat_in)
    );

    // 64-bit instance
    logic [1:0]  q_op = '0, q_size = '0;
    logic        q_sgn = 1'b0, q_valid = 1'b0, q_ack = 1'b0;
    logic [63:0] q_addr = '0, q_dat_in = '0;
    logic [4:0]  q_dst = '0;
    logic        q_rdy, q_wbw, q_flt, q_we, q_stb, q_cyc;
    logic [63:0] q_wb_pay, q_f_addr, q_dat_out;
    logic [4:0]  q_wb_dst;
    logic [1:0]  q_f_code;
    logic [60:0] q_bus_addr;
    logic [7:0]  q_sel;

    mr_ldst_pipe #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst),
        .ex_op_i(q_op), .ex_size_i(q_size), .ex_signed_i(q_sgn), .ex_addr_i(q_addr),
        .ex_payload_i(64'd0), .ex_dst_reg_i(q_dst), .ex_valid_i(q_valid), .ex_ready_o(q_rdy),
        .wb_write(q_wbw), .wb_payload_o(q_wb_pay), .wb_dst_reg_o(q_wb_dst),
        .fault_o(q_flt), .fault_code_o(q_f_code), .fault_addr_o(q_f_addr),
        .addr_o(q_bus_addr), .we_o(q_we), .sel_o(q_sel), .dat_o(q_dat_out),
        .stb_o(q_stb), .cyc_o(q_cyc), .ack_i(q_ack), .err_i(1'b0), .stall_i(1'b0),
        .dat_i(q_dat_in)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] o, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] p, input logic [4:0] d);
        op = o; size = s; sgn = sg; addr = a; pay = p; dst = d; valid = 1'b1;
    endtask

    logic [4:0] exp_dst [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};

    initial begin
        // reset
        repeat (3) step();
        check("rst_stb", stb, 0);
        check("rst_cyc", cyc, 0);
        check("rst_wb", wbw, 0);
        check("rst_fault", flt, 0);
        rst = 1'b1;
        #1 check("rst_ready", rdy, 1);

        // LB signed at 0x1003
        step();
        req(2'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd5);
        #1 check("lb_ready", rdy, 1);
        step();
        valid = 1'b0;
        check("lb_stb", stb, 1);
        check("lb_addr", bus_addr, 30'h400);
        check("lb_sel", sel, 4'b1000);
        check("lb_we", we, 0);
        ack = 1'b1; dat_in = 32'h8000_0000;
        step();
        ack = 1'b0;
        check("lb_wb", wbw, 1);
        check("lb_pay", wb_pay, 32'hFFFF_FF80);
        check("lb_dst", wb_dst, 5'd5);
        check("lb_cyc_drop", cyc, 0);

        // four back-to-back LW, acks start once all four are issued
        step();
        req(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 5'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("b2b_stb", stb, 1);
            check("b2b_addr", bus_addr, 30'h40 + 30'(k - 1));
            req(2'd1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 5'(k + 1));
        end
        step();
        check("b2b_stb4", stb, 1);
        check("b2b_addr4", bus_addr, 30'h43);
        req(2'd1, 2'd2, 1'b0, 32'h110, 32'h0, 5'd6);
        #1 check("b2b_full_ready", rdy, 0);
        ack = 1'b1; dat_in = 32'h1111_1111;
        step();
        check("b2b_gap_stb", stb, 0);
        #1 check("b2b_ready_after_ack", rdy, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            if (k == 1) begin
                valid = 1'b0;
                check("b2b_stb5", stb, 1);
                check("b2b_addr5", bus_addr, 30'h44);
            end
            check("b2b_wb", wbw, 1);
            check("b2b_pay", wb_pay, 32'h1111_1111 * 32'(k + 1));
            check("b2b_dst", wb_dst, exp_dst[k]);
            if (k < 4) dat_in = 32'h1111_1111 * 32'(k + 2);
            else ack = 1'b0;
        end
        check("b2b_cyc_drop", cyc, 0);

        // SH 0xBEEF to 0x2002 under a 3-cycle stall
        step();
        req(2'd2, 2'd1, 1'b0, 32'h2002, 32'hBEEF, 5'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            valid = 1'b0;
            check("sh_stb", stb, 1);
            check("sh_addr", bus_addr, 30'h800);
            check("sh_dat", dat_out, 32'hBEEF_BEEF);
            check("sh_sel", sel, 4'b1100);
            check("sh_we", we, 1);
            #1 check("sh_ready_stall", rdy, 0);
        end
        stall = 1'b0;
        step();
        check("sh_stb_done", stb, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sh_no_wb", wbw, 0);
        check("sh_cyc_drop", cyc, 0);

        // misaligned LW
        step();
        req(2'd1, 2'd2, 1'b0, 32'h1002, 32'h0, 5'd0);
        #1 check("mis_ready", rdy, 1);
        step();
        valid = 1'b0;
        check("mis_stb", stb, 0);
        check("mis_fault", flt, 1);
        check("mis_code", f_code, 2'd1);
        check("mis_addr", f_addr, 32'h1002);
        #1 check("mis_ready_fault", rdy, 0);
        step();
        check("mis_fault_pulse", flt, 0);

        // 8-byte access on a 32-bit bus is an illegal size
        req(2'd1, 2'd3, 1'b0, 32'h40, 32'h0, 5'd0);
        step();
        valid = 1'b0;
        check("ill_fault", flt, 1);
        check("ill_code", f_code, 2'd3);
        check("ill_addr", f_addr, 32'h40);
        check("ill_stb", stb, 0);

        // NONE pass-through
        step();
        req(2'd0, 2'd0, 1'b0, 32'hCAFE, 32'h0, 5'd7);
        step();
        valid = 1'b0;
        check("none_wb", wbw, 1);
        check("none_pay", wb_pay, 32'hCAFE);
        check("none_dst", wb_dst, 5'd7);
        check("none_fault", flt, 0);

        // bus error with two loads outstanding
        step();
        req(2'd1, 2'd2, 1'b0, 32'h300, 32'h0, 5'd1);
        step();
        req(2'd1, 2'd2, 1'b0, 32'h304, 32'h0, 5'd2);
        step();
        valid = 1'b0;
        err = 1'b1;
        step();
        err = 1'b0;
        check("err_cyc", cyc, 0);
        check("err_stb", stb, 0);
        check("err_fault", flt, 1);
        check("err_code", f_code, 2'd2);
        check("err_addr", f_addr, 32'h300);
        check("err_no_wb", wbw, 0);
        step();
        check("err_fault_pulse", flt, 0);
        #1 check("err_ready_after", rdy, 1);
        ack = 1'b1; dat_in = 32'h0000_0123;
        step();
        ack = 1'b0;
        check("err_stale_ack", wbw, 0);

        // 64-bit: LD from 0x8, then LH unsigned at 0xE
        q_op = 2'd1; q_size = 2'd3; q_sgn = 1'b0; q_addr = 64'h8; q_dst = 5'd9; q_valid = 1'b1;
        step();
        q_valid = 1'b0;
        check("ld64_stb", q_stb, 1);
        check("ld64_addr", q_bus_addr, 61'h1);
        check("ld64_sel", q_sel, 8'hFF);
        q_ack = 1'b1; q_dat_in = 64'h0123_4567_89AB_CDEF;
        step();
        q_ack = 1'b0;
        check("ld64_wb", q_wbw, 1);
        check("ld64_pay", q_wb_pay, 64'h0123_4567_89AB_CDEF);
        check("ld64_dst", q_wb_dst, 5'd9);
        q_size = 2'd1; q_addr = 64'hE; q_dst = 5'd10; q_valid = 1'b1;
        step();
        q_valid = 1'b0;
        check("lh64_sel", q_sel, 8'b1100_0000);
        check("lh64_addr", q_bus_addr, 61'h1);
        q_ack = 1'b1; q_dat_in = 64'h8001_0000_0000_0000;
        step();
        q_ack = 1'b0;
        check("lh64_wb", q_wbw, 1);
        check("lh64_pay", q_wb_pay, 64'h8001);
        check("lh64_dst", q_wb_dst, 5'd10);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
